// File: rtl/main_mem_ctrl_if.sv
// main_mem_ctrl_if
// Block-transfer bus between the cache (master) and main memory (slave).
//   req          : request valid, held stable by the master until done
//   readWriteOut : 1 = block read, 0 = block write
//   memAddr      : byte address, block index in bits [9:4]
//   writeDataMem : 128-bit block to write (word 0 in bits [31:0])
//   readDataMem  : 128-bit block returned by a read
//   done         : one-cycle completion pulse
//   busy         : high from acceptance through the done cycle
interface main_mem_ctrl_if;
  logic         req;
  logic         readWriteOut;
  logic [9:0]   memAddr;
  logic [127:0] writeDataMem;
  logic [127:0] readDataMem;
  logic         done;
  logic         busy;

  modport master (
    output req, readWriteOut, memAddr, writeDataMem,
    input  readDataMem, done, busy
  );

  modport slave (
    input  req, readWriteOut, memAddr, writeDataMem,
    output readDataMem, done, busy
  );
endinterface

// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl
// Main-memory model and controller sitting directly below the cache. It holds
// BLOCKS 128-bit blocks and serves one block read or write-back at a time,
// with a fixed LATENCY from request acceptance to the done pulse.
//
// Ports:
//   clock      : system clock, all state changes on the rising edge
//   reset_n    : synchronous active-low reset, clears the store as well
//   bus        : main_mem_ctrl_if.slave (req/done handshake and data)
//   readCount  : completed reads (statistics build only, else 0)
//   writeCount : completed writes (statistics build only, else 0)
//
// Build option:
//   MAIN_MEM_STATS_EN : when defined, readCount/writeCount are live 16-bit
//                       wrapping counters; when undefined they are tied to 0.
module main_mem_ctrl #(
  parameter int LATENCY = 4,
  parameter int BLOCKS  = 64
) (
  input  logic           clock,
  input  logic           reset_n,
  main_mem_ctrl_if.slave bus,
  output logic [15:0]    readCount,
  output logic [15:0]    writeCount
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } stateT;

  // The counter is loaded with LATENCY-1 so the done pulse lands exactly
  // LATENCY edges after the acceptance edge.
  localparam logic [3:0] LAT_START = 4'(LATENCY - 1);

  stateT        state;
  logic [3:0]   counter;
  logic         latchedRead;
  logic [5:0]   latchedIndex;
  logic [127:0] latchedData;
  logic [127:0] store [BLOCKS];
  logic [127:0] readData;
  logic         doneReg;
  logic         busyReg;

  // The byte offset within a block never selects anything.
  logic unusedOffset;
  assign unusedOffset = ^bus.memAddr[3:0];

  assign bus.readDataMem = readData;
  assign bus.done        = doneReg;
  assign bus.busy        = busyReg;

  // Request sequencer and store. The request is captured on acceptance so
  // the master's inputs are irrelevant while the access is in flight; the
  // store is only touched on the final ACCESS edge, so a reset during
  // ACCESS discards the pending write.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      counter      <= 4'd0;
      latchedRead  <= 1'b0;
      latchedIndex <= 6'd0;
      latchedData  <= '0;
      readData     <= '0;
      doneReg      <= 1'b0;
      busyReg      <= 1'b0;
      for (int i = 0; i < BLOCKS; i++) begin
        store[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          doneReg <= 1'b0;
          if (bus.req) begin
            latchedRead  <= bus.readWriteOut;
            latchedIndex <= bus.memAddr[9:4];
            latchedData  <= bus.writeDataMem;
            counter      <= LAT_START;
            busyReg      <= 1'b1;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (counter == 4'd0) begin
            if (latchedRead) begin
              readData <= store[latchedIndex];
            end else begin
              store[latchedIndex] <= latchedData;
            end
            doneReg <= 1'b1;
            state   <= DONE;
          end else begin
            counter <= counter - 4'd1;
          end
        end
        DONE: begin
          doneReg <= 1'b0;
          busyReg <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MAIN_MEM_STATS_EN
  // Completion counters advance on the same edge that commits the access.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      readCount  <= 16'd0;
      writeCount <= 16'd0;
    end else if (state == ACCESS && counter == 4'd0) begin
      if (latchedRead) begin
        readCount <= readCount + 16'd1;
      end else begin
        writeCount <= writeCount + 16'd1;
      end
    end
  end
`else
  assign readCount  = 16'd0;
  assign writeCount = 16'd0;
`endif

endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb_main_mem_ctrl
// Self-checking bench for main_mem_ctrl. A timeline model (acceptance cycle
// plus fixed latency, plain array for the store) predicts done, busy,
// readDataMem and the counters; a negedge process compares every cycle.
// Directed scenarios add literal expectations, then a randomized phase runs.
`timescale 1ns/1ps
module tb_main_mem_ctrl;

  localparam int LATENCY  = 4;
  localparam int BLOCKS   = 64;
  localparam int MAX_WAIT = 40;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] readCount;
  logic [15:0] writeCount;

  main_mem_ctrl_if bus();

  main_mem_ctrl #(.LATENCY(LATENCY), .BLOCKS(BLOCKS)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .readCount  (readCount),
    .writeCount (writeCount)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference model: a request accepted at cycle t completes at t+LATENCY
  // and the controller is free again at t+LATENCY+1.
  logic [127:0] modelMem [BLOCKS];
  int           cyc = 0;
  bit           pending = 1'b0;
  int           acceptCyc = 0;
  bit           opRead;
  int           opIdx;
  logic [127:0] opData;
  bit           expDone = 1'b0;
  bit           expBusy = 1'b0;
  logic [127:0] expRd = '0;
  int           expReads = 0;
  int           expWrites = 0;

  always @(posedge clock) begin
    cyc++;
    if (!reset_n) begin
      for (int i = 0; i < BLOCKS; i++) modelMem[i] = '0;
      pending   = 1'b0;
      expDone   = 1'b0;
      expBusy   = 1'b0;
      expRd     = '0;
      expReads  = 0;
      expWrites = 0;
    end else if (pending && cyc == acceptCyc + LATENCY) begin
      if (opRead) begin
        expRd = modelMem[opIdx];
        expReads++;
      end else begin
        modelMem[opIdx] = opData;
        expWrites++;
      end
      expDone = 1'b1;
    end else if (pending && cyc == acceptCyc + LATENCY + 1) begin
      pending = 1'b0;
      expDone = 1'b0;
      expBusy = 1'b0;
    end else if (!pending && bus.req === 1'b1) begin
      pending   = 1'b1;
      acceptCyc = cyc;
      opRead    = bus.readWriteOut;
      opIdx     = int'(bus.memAddr) / 16;
      opData    = bus.writeDataMem;
      expBusy   = 1'b1;
    end
  end

  // Per-cycle comparison against the model.
  logic prevDone = 1'b0;
  always @(negedge clock) begin
    if (checkEn) begin
      logic [15:0] expRc;
      logic [15:0] expWc;
`ifdef MAIN_MEM_STATS_EN
      expRc = 16'(expReads);
      expWc = 16'(expWrites);
`else
      expRc = 16'd0;
      expWc = 16'd0;
`endif
      checkOutput("done", 128'(bus.done), 128'(expDone));
      checkOutput("busy", 128'(bus.busy), 128'(expBusy));
      checkOutput("readDataMem", bus.readDataMem, expRd);
      checkOutput("readCount", 128'(readCount), 128'(expRc));
      checkOutput("writeCount", 128'(writeCount), 128'(expWc));
      checkOutput("doneTwice", 128'(prevDone & bus.done), 128'(0));
      prevDone = bus.done;
    end
  end

  task automatic resetDut();
    @(negedge clock);
    reset_n = 1'b0;
    bus.req = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Issue one request and wait (bounded) for done. Optionally scramble the
  // request inputs right after acceptance to prove they are latched.
  task automatic applyStimulus(input bit isRead, input logic [9:0] addr, input logic [127:0] data,
                               input bit scramble, output int latency, output int busyCycles);
    @(negedge clock);
    bus.req          = 1'b1;
    bus.readWriteOut = isRead;
    bus.memAddr      = addr;
    bus.writeDataMem = data;
    latency    = -1;
    busyCycles = 0;
    for (int n = 1; n <= MAX_WAIT; n++) begin
      @(negedge clock);
      if (n == 1) begin
        bus.req = 1'b0;
        if (scramble) begin
          bus.memAddr      = 10'h3F0;
          bus.readWriteOut = 1'b0;
          bus.writeDataMem = {4{32'hDEADBEEF}};
        end
      end
      if (bus.busy) busyCycles++;
      if (bus.done) begin
        latency = n - 1;
        break;
      end
    end
    if (latency < 0) checkOutput("doneTimeout", 128'(bus.done), 128'(1));
    bus.req = 1'b0;
    @(negedge clock);
    if (bus.busy) busyCycles++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int bsy;
    int doneSeen;
    int lastDone;
    logic [127:0] dataA;
    logic [127:0] blk1;
    logic [127:0] w4a;
    logic [127:0] w4b;

    reset_n          = 1'b0;
    bus.req          = 1'b0;
    bus.readWriteOut = 1'b0;
    bus.memAddr      = '0;
    bus.writeDataMem = '0;
    dataA = 128'h44444444_33333333_22222222_11111111;
    blk1  = 128'hA5A5A5A5_0F0F0F0F_12345678_CAFEF00D;
    w4a   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    w4b   = 128'h55555555_66666666_77777777_88888888;

    resetDut();
    checkEn = 1'b1;
    checkOutput("resetReadData", bus.readDataMem, 128'h0);
    checkOutput("resetBusy", 128'(bus.busy), 128'(0));
    checkOutput("resetDone", 128'(bus.done), 128'(0));

    // Read of a freshly cleared block: latency 4, busy for 5 cycles.
    applyStimulus(1'b1, 10'h000, '0, 1'b0, lat, bsy);
    checkOutput("t1 latency", 128'(lat), 128'(4));
    checkOutput("t1 busyCycles", 128'(bsy), 128'(5));
    checkOutput("t1 readData", bus.readDataMem, 128'h0);

    // Write then read back via a different offset in the same block.
    applyStimulus(1'b0, 10'h1A4, dataA, 1'b0, lat, bsy);
    checkOutput("t2 writeLatency", 128'(lat), 128'(4));
    applyStimulus(1'b1, 10'h1A0, '0, 1'b0, lat, bsy);
    checkOutput("t2 readBack", bus.readDataMem, 128'h44444444_33333333_22222222_11111111);
    applyStimulus(1'b1, 10'h1B0, '0, 1'b0, lat, bsy);
    checkOutput("t2 neighbour", bus.readDataMem, 128'h0);

    // Inputs changed during ACCESS must not affect the latched read.
    applyStimulus(1'b0, 10'h010, blk1, 1'b0, lat, bsy);
    applyStimulus(1'b1, 10'h010, '0, 1'b1, lat, bsy);
    checkOutput("t3 latchedRead", bus.readDataMem, 128'hA5A5A5A5_0F0F0F0F_12345678_CAFEF00D);
    applyStimulus(1'b1, 10'h3F0, '0, 1'b0, lat, bsy);
    checkOutput("t3 block63Untouched", bus.readDataMem, 128'h0);

    // req held high: write/read/write/read to block 63, one every 6 cycles.
    @(negedge clock);
    bus.req          = 1'b1;
    bus.readWriteOut = 1'b0;
    bus.memAddr      = 10'h3FC;
    bus.writeDataMem = w4a;
    doneSeen = 0;
    lastDone = 0;
    for (int n = 1; n <= 60 && doneSeen < 4; n++) begin
      @(negedge clock);
      if (bus.done) begin
        doneSeen++;
        if (doneSeen > 1) checkOutput("t4 interval", 128'(n - lastDone), 128'(6));
        lastDone = n;
        case (doneSeen)
          1: bus.readWriteOut = 1'b1;
          2: begin
            checkOutput("t4 readBack1", bus.readDataMem, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
            bus.readWriteOut = 1'b0;
            bus.writeDataMem = w4b;
          end
          3: bus.readWriteOut = 1'b1;
          default: begin
            checkOutput("t4 readBack2", bus.readDataMem, 128'h55555555_66666666_77777777_88888888);
            bus.req = 1'b0;
          end
        endcase
      end
    end
    if (doneSeen < 4) checkOutput("t4 timeout", 128'(doneSeen), 128'(4));
    bus.req = 1'b0;

    // Reset in the middle of a write: no done, store stays cleared.
    @(negedge clock);
    bus.req          = 1'b1;
    bus.readWriteOut = 1'b0;
    bus.memAddr      = 10'h020;
    bus.writeDataMem = {4{32'h0BADC0DE}};
    @(negedge clock);
    bus.req = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    checkOutput("t5 busyAfterReset", 128'(bus.busy), 128'(0));
    checkOutput("t5 doneAfterReset", 128'(bus.done), 128'(0));
    repeat (LATENCY + 3) begin
      @(negedge clock);
      checkOutput("t5 noDone", 128'(bus.done), 128'(0));
    end
    applyStimulus(1'b1, 10'h020, '0, 1'b0, lat, bsy);
    checkOutput("t5 notCommitted", bus.readDataMem, 128'h0);

    // Statistics: 3 reads and 2 writes from a clean reset.
    resetDut();
    applyStimulus(1'b0, 10'h040, w4a, 1'b0, lat, bsy);
    applyStimulus(1'b1, 10'h040, '0, 1'b0, lat, bsy);
    applyStimulus(1'b0, 10'h050, w4b, 1'b0, lat, bsy);
    applyStimulus(1'b1, 10'h050, '0, 1'b0, lat, bsy);
    applyStimulus(1'b1, 10'h060, '0, 1'b0, lat, bsy);
`ifdef MAIN_MEM_STATS_EN
    checkOutput("t6 readCount", 128'(readCount), 128'(3));
    checkOutput("t6 writeCount", 128'(writeCount), 128'(2));
`else
    checkOutput("t6 readCount", 128'(readCount), 128'(0));
    checkOutput("t6 writeCount", 128'(writeCount), 128'(0));
`endif

    // Randomized traffic over a small block pool so reads hit prior writes.
    for (int k = 0; k < 60; k++) begin
      int idx;
      logic [9:0] addr;
      logic [127:0] data;
      idx  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(60, 63));
      addr = 10'(idx * 16 + int'($urandom_range(0, 15)));
      data = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 1)), addr, data, 1'($urandom_range(0, 1)), lat, bsy);
      checkOutput("rand latency", 128'(lat), 128'(4));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    @(negedge clock);
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
